// File: rtl/frame_pkg.sv
// Shared types and constants for the frame aligner: FSM state encoding,
// the default sync pattern and the frame-length helper.
package frame_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // One sync word plus the payload words.
  function automatic int frame_len(input int num_words);
    return num_words + 1;
  endfunction

endpackage

// File: rtl/frame_aligner.sv
// Frame aligner: hunts for SYNC_WORD, confirms alignment over LOCK_COUNT frames,
// forwards payload words with start-of-frame marking, and flywheels over bad syncs.
module frame_aligner
  import frame_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               NUM_WORDS    = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD    = WIDTH'(DEFAULT_SYNC_WORD),
  parameter int               LOCK_COUNT   = 2,
  parameter int               UNLOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dv,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dv,
  output logic             o_sof,
  output logic             o_locked,
  output logic             o_sync_err
);

  localparam int PHASE_W = $clog2(frame_len(NUM_WORDS));
  localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(NUM_WORDS);
  localparam logic [PHASE_W-1:0] FIRST_PAYLD = PHASE_W'(1);
  localparam logic [GOOD_W-1:0]  GOOD_LIMIT  = GOOD_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  MISS_LIMIT  = MISS_W'(UNLOCK_COUNT);

  state_t             state, state_n;
  logic [PHASE_W-1:0] phase, phase_n, phase_adv;
  logic [GOOD_W-1:0]  good_cnt, good_n, good_inc;
  logic [MISS_W-1:0]  miss_cnt, miss_n, miss_inc;
  logic [WIDTH-1:0]   data_n;
  logic               dv_n, sof_n, err_n;
  logic               is_sync;

  assign is_sync   = (i_data == SYNC_WORD);
  assign phase_adv = (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
  assign good_inc  = good_cnt + GOOD_W'(1);
  assign miss_inc  = miss_cnt + MISS_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    phase_n = phase;
    good_n  = good_cnt;
    miss_n  = miss_cnt;
    data_n  = o_data;
    dv_n    = 1'b0;
    sof_n   = 1'b0;
    err_n   = 1'b0;

    if (i_dv) begin
      unique case (state)
        HUNT: begin
          if (is_sync) begin
            state_n = VERIFY;
            phase_n = FIRST_PAYLD;
            good_n  = GOOD_W'(1);
          end
        end

        VERIFY: begin
          if (phase != '0) begin
            phase_n = phase_adv;
          end else if (is_sync) begin
            phase_n = FIRST_PAYLD;
            if (good_inc == GOOD_LIMIT) begin
              state_n = LOCKED;
              good_n  = '0;
              miss_n  = '0;
            end else begin
              good_n = good_inc;
            end
          end else begin
            // The failing word is dropped, not re-examined as a new sync.
            state_n = HUNT;
            phase_n = '0;
            good_n  = '0;
          end
        end

        LOCKED: begin
          if (phase != '0) begin
            data_n  = i_data;
            dv_n    = 1'b1;
            sof_n   = (phase == FIRST_PAYLD);
            phase_n = phase_adv;
          end else if (is_sync) begin
            miss_n  = '0;
            phase_n = FIRST_PAYLD;
          end else begin
            err_n = 1'b1;
            if (miss_inc == MISS_LIMIT) begin
              state_n = HUNT;
              phase_n = '0;
              miss_n  = '0;
            end else begin
              // Flywheel: the bad word still occupies the sync slot.
              miss_n  = miss_inc;
              phase_n = FIRST_PAYLD;
            end
          end
        end

        default: begin
          state_n = HUNT;
          phase_n = '0;
          good_n  = '0;
          miss_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= HUNT;
      phase      <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      o_data     <= '0;
      o_dv       <= 1'b0;
      o_sof      <= 1'b0;
      o_locked   <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state      <= state_n;
      phase      <= phase_n;
      good_cnt   <= good_n;
      miss_cnt   <= miss_n;
      o_data     <= data_n;
      o_dv       <= dv_n;
      o_sof      <= sof_n;
      o_locked   <= (state_n == LOCKED);
      o_sync_err <= err_n;
    end
  end

endmodule

// File: tb/tb_frame_aligner.sv
// Self-checking bench for frame_aligner: directed scenarios plus randomized
// framed traffic compared cycle by cycle against a behavioural model.
module tb_frame_aligner;

  localparam int         W      = 8;
  localparam int         N      = 4;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         LOCK   = 2;
  localparam int         UNLOCK = 2;

  logic         clk = 1'b0;
  logic         i_reset_n = 1'b1;
  logic [W-1:0] i_data = '0;
  logic         i_dv = 1'b0;
  logic [W-1:0] o_data;
  logic         o_dv, o_sof, o_locked, o_sync_err;

  int n_checks = 0;
  int n_fail   = 0;
  int gap      = 0;

  // Model: mode 0=hunting, 1=verifying, 2=locked; left = payload words
  // still owed by the current frame (0 means the next word is a sync slot).
  int         m_mode, m_left, m_good, m_miss;
  logic [7:0] exp_data;
  logic       exp_dv, exp_sof, exp_err, exp_locked;

  frame_aligner #(
    .WIDTH(W), .NUM_WORDS(N), .SYNC_WORD(SYNC),
    .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_dv(i_dv),
    .o_data(o_data), .o_dv(o_dv), .o_sof(o_sof),
    .o_locked(o_locked), .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("o_dv", 32'(o_dv), 32'(exp_dv));
    check("o_data", 32'(o_data), 32'(exp_data));
    check("o_sof", 32'(o_sof), 32'(exp_sof));
    check("o_sync_err", 32'(o_sync_err), 32'(exp_err));
    check("o_locked", 32'(o_locked), 32'(exp_locked));
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_good = 0; m_miss = 0;
    exp_data = '0; exp_dv = 0; exp_sof = 0; exp_err = 0; exp_locked = 0;
  endtask

  task automatic model_word(input logic [7:0] w);
    exp_dv = 0; exp_sof = 0; exp_err = 0;
    if (m_left > 0) begin
      if (m_mode == 2) begin
        exp_dv   = 1;
        exp_data = w;
        exp_sof  = (m_left == N);
      end
      m_left--;
    end else if (m_mode == 0) begin
      if (w == SYNC) begin m_mode = 1; m_good = 1; m_left = N; end
    end else if (m_mode == 1) begin
      if (w == SYNC) begin
        m_good++;
        m_left = N;
        if (m_good == LOCK) begin m_mode = 2; m_miss = 0; end
      end else begin
        m_mode = 0; m_good = 0;
      end
    end else begin
      if (w == SYNC) begin
        m_miss = 0; m_left = N;
      end else begin
        exp_err = 1;
        m_miss++;
        if (m_miss == UNLOCK) begin m_mode = 0; m_miss = 0; end
        else m_left = N;
      end
    end
    exp_locked = (m_mode == 2);
  endtask

  // One clock: check what the previous cycle produced, then drive this cycle.
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    compare_outputs();
    i_dv   = v;
    i_data = d;
    if (v) model_word(d);
    else begin exp_dv = 0; exp_sof = 0; exp_err = 0; end
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d);
    for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] s);
    send(s);
    for (int k = 0; k < N; k++) send(8'($urandom_range(1, 8) == 1 ? SYNC : $urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 i_reset_n = 1'b0;
    i_dv = 1'b0;
    #1;
    check("rst_o_dv", 32'(o_dv), 32'd0);
    check("rst_o_sof", 32'(o_sof), 32'd0);
    check("rst_o_locked", 32'(o_locked), 32'd0);
    check("rst_o_sync_err", 32'(o_sync_err), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    model_reset();
    #1 i_reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] acq [10];
    logic [7:0] fl  [9];
    acq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88};
    fl  = '{8'h00, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9C, 8'h11, 8'h22};
    model_reset();
    do_reset();

    // Acquisition from reset, back-to-back.
    foreach (acq[i]) send(acq[i]);
    step(1'b0, 8'h00);

    // Payload containing the sync value, then a single flywheel miss.
    send(SYNC); send(8'h55); send(SYNC); send(8'h77); send(8'h88);
    send(8'h5A); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(SYNC); send(8'h10); send(8'h20); send(8'h30); send(8'h40);

    // Gapped locked traffic.
    gap = 3;
    send_frame(SYNC);
    send_frame(SYNC);
    gap = 0;

    // Two consecutive bad syncs drop lock; trailing payload is not forwarded.
    send(8'h5A); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h5A); send(8'h21); send(8'h22); send(8'h23); send(8'h24);

    // Reset mid-frame while locked, then a fresh acquisition.
    send_frame(SYNC); send_frame(SYNC); send(SYNC); send(8'h99);
    do_reset();
    send(8'h98); send(8'h97);
    send_frame(SYNC); send_frame(SYNC); send_frame(SYNC);

    // False lock caught in verification.
    do_reset();
    foreach (fl[i]) send(fl[i]);
    step(1'b0, 8'h00);

    // Randomized framed traffic with gaps, garbage, bad syncs and resets.
    for (int f = 0; f < 300; f++) begin
      int r;
      r   = int'($urandom_range(0, 19));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (r == 0) do_reset();
      else if (r < 3) send(8'($urandom));
      else if (r < 5) send_frame(8'h5A);
      else send_frame(SYNC);
    end
    gap = 0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
